// File: rtl/dsp_add_pipe.sv
// dsp_add_pipe: two-stage pipelined 32-bit unsigned adder with valid/ready
// handshakes on both sides.
//
// The add is split into 16-bit halves. Stage 1 adds the low halves and
// registers the carry. Stage 2 adds the high halves plus that carry. Each
// stage therefore has only a 16-bit carry chain.
//
// Optional feature macro: DSP_ADD_SUB_EN
//   When defined, the block gains a 'sub' input that is sampled with the
//   operands. With sub = 1 the block computes input1 - input2 mod 2^32.
//   In that mode carry_out = 1 means no borrow.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands presented
//   in_ready   block accepts operands this cycle (combinational)
//   input1     augend
//   input2     addend
//   sub        subtract select (only with DSP_ADD_SUB_EN)
//   out_valid  result valid
//   out_ready  consumer accepts result this cycle
//   out        sum[31:0]
//   carry_out  sum bit 32
module dsp_add_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
`ifdef DSP_ADD_SUB_EN
    input  logic        sub,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        carry_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [HALF_W-1:0] lo_sum_q,   lo_sum_d;
    logic              c16_q,      c16_d;
    logic [HALF_W-1:0] hi_a_q,     hi_a_d;
    logic [HALF_W-1:0] hi_b_q,     hi_b_d;

    // Stage 2 state
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] out_q,      out_d;
    logic              carry_q,    carry_d;

    logic              adv1, adv2;
    logic [DATA_W-1:0] b_eff;
    logic              cin;
    logic [HALF_W:0]   lo_full;
    logic [HALF_W:0]   hi_full;

    // Select the effective second operand and carry-in
    always_comb begin
`ifdef DSP_ADD_SUB_EN
        b_eff = sub ? ~input2 : input2;
        cin   = sub;
`else
        b_eff = input2;
        cin   = 1'b0;
`endif
    end

    // Next-state logic for both stages
    always_comb begin
        adv2 = !s2_valid_q || out_ready;
        adv1 = !s1_valid_q || adv2;

        lo_full = {1'b0, input1[HALF_W-1:0]} + {1'b0, b_eff[HALF_W-1:0]}
                + (HALF_W+1)'(cin);
        hi_full = (HALF_W+1)'(hi_a_q) + (HALF_W+1)'(hi_b_q)
                + (HALF_W+1)'(c16_q);

        s1_valid_d = s1_valid_q;
        lo_sum_d   = lo_sum_q;
        c16_d      = c16_q;
        hi_a_d     = hi_a_q;
        hi_b_d     = hi_b_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        carry_d    = carry_q;

        // Data registers change only when a valid item is actually loaded.
        // Bubbles update the valid bit and leave the data untouched.
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                lo_sum_d = lo_full[HALF_W-1:0];
                c16_d    = lo_full[HALF_W];
                hi_a_d   = input1[DATA_W-1:HALF_W];
                hi_b_d   = b_eff[DATA_W-1:HALF_W];
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d   = {hi_full[HALF_W-1:0], lo_sum_q};
                carry_d = hi_full[HALF_W];
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            c16_q      <= 1'b0;
            hi_a_q     <= '0;
            hi_b_q     <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            carry_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            lo_sum_q   <= lo_sum_d;
            c16_q      <= c16_d;
            hi_a_q     <= hi_a_d;
            hi_b_q     <= hi_b_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_dsp_add_pipe.sv
// Directed testbench for dsp_add_pipe with hand-computed expected values.
module tb_dsp_add_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
`ifdef DSP_ADD_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        carry_out;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [32:0] got_q[$];
    int          cyc_q[$];

    dsp_add_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
`ifdef DSP_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Record each output transfer, sampled mid-cycle before the edge commits it
    always @(negedge clk) begin
        if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back({carry_out, out});
            cyc_q.push_back(cycle);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an empty pipe with out_ready=1 and check timing and result
    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out,
                          input logic exp_co);
        input1   = a;
        input2   = b;
        in_valid = 1'b1;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        tick;
        in_valid = 1'b0;
        check_eq({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
        tick;
        check_eq({tag, "_valid"}, 64'(out_valid), 64'(1));
        check_eq({tag, "_out"}, 64'(out), 64'(exp_out));
        check_eq({tag, "_co"}, 64'(carry_out), 64'(exp_co));
        tick;
        check_eq({tag, "_after_valid"}, 64'(out_valid), 64'(0));
    endtask

    logic [31:0] stream_exp [8];
    logic [32:0] bp_exp [3];

    initial begin
        stream_exp = '{32'h0000_0000, 32'h1000_0001, 32'h2000_0002,
                       32'h3000_0003, 32'h4000_0004, 32'h5000_0005,
                       32'h6000_0006, 32'h7000_0007};
        bp_exp = '{33'h0_2345_6789, 33'h1_0000_0000, 33'h0_0001_FFFE};

        rst       = 1'b1;
        in_valid  = 1'b0;
        input1    = '0;
        input2    = '0;
        out_ready = 1'b1;
`ifdef DSP_ADD_SUB_EN
        sub       = 1'b0;
`endif
        #3;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out", 64'(out), 64'(0));
        check_eq("rst_co", 64'(carry_out), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Single op and carry/overflow corner cases
        run_op("add_1_2", 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0);
        run_op("carry_mid", 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0);
        run_op("wrap_all", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        run_op("msb_ovf", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

        // Back-to-back streaming
        got_q.delete();
        cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            input1   = 32'(i);
            input2   = 32'h1000_0000 * 32'(i);
            in_valid = 1'b1;
            check_eq($sformatf("stream_in_ready_%0d", i), 64'(in_ready), 64'(1));
            tick;
        end
        in_valid = 1'b0;
        repeat (4) tick;
        check_eq("stream_count", 64'(got_q.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) begin
                check_eq($sformatf("stream_val_%0d", i), 64'(got_q[i]),
                         64'({1'b0, stream_exp[i]}));
                check_eq($sformatf("stream_cyc_%0d", i), 64'(cyc_q[i] - cyc_q[0]),
                         64'(i));
            end
        end

        // Backpressure: fill both stages with the consumer stalled
        got_q.delete();
        cyc_q.delete();
        out_ready = 1'b0;
        input1 = 32'h1234_5678; input2 = 32'h1111_1111; in_valid = 1'b1;
        tick;
        input1 = 32'hFFFF_0000; input2 = 32'h0001_0000;
        check_eq("bp_in_ready_b", 64'(in_ready), 64'(1));
        tick;
        input1 = 32'h0000_FFFF; input2 = 32'h0000_FFFF;
        check_eq("bp_in_ready_full", 64'(in_ready), 64'(0));
        check_eq("bp_valid", 64'(out_valid), 64'(1));
        for (int k = 0; k < 3; k++) begin
            tick;
            check_eq($sformatf("bp_hold_out_%0d", k), 64'({carry_out, out}),
                     64'(bp_exp[0]));
            check_eq($sformatf("bp_hold_valid_%0d", k), 64'(out_valid), 64'(1));
            check_eq($sformatf("bp_hold_ready_%0d", k), 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 64'(in_ready), 64'(1));
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        check_eq("bp_count", 64'(got_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size())
                check_eq($sformatf("bp_val_%0d", i), 64'(got_q[i]), 64'(bp_exp[i]));
        end

        // Reset mid-flight with both stages occupied
        out_ready = 1'b0;
        input1 = 32'h0000_0005; input2 = 32'h0000_0006; in_valid = 1'b1;
        tick;
        input1 = 32'h0000_0007; input2 = 32'h0000_0008;
        tick;
        in_valid = 1'b0;
        check_eq("mid_pre_valid", 64'(out_valid), 64'(1));
        check_eq("mid_pre_out", 64'(out), 64'(32'h0000_000B));
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
        check_eq("mid_rst_out", 64'(out), 64'(0));
        check_eq("mid_rst_co", 64'(carry_out), 64'(0));
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'(1));
        tick;
        tick;
        rst = 1'b0;
        got_q.delete();
        cyc_q.delete();
        out_ready = 1'b1;
        repeat (4) tick;
        check_eq("mid_no_stale", 64'(got_q.size()), 64'(0));
        check_eq("mid_post_valid", 64'(out_valid), 64'(0));

`ifdef DSP_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
        run_op("sub_7_5", 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1);
        run_op("sub_borrow_mid", 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b1);
        sub = 1'b0;
        run_op("add_after_sub", 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
